obi_block_dma: RTL and testbench
================================

// Module: obi_block_dma
// PURPOSE
//  OBI data-bus initiator that feeds the AES core. Per command it reads N blocks of BLK_WORDS words
//  from src, hands each block to the core, and writes the core's result block to dst. It sits
//  between the command/CSR logic and the shared data memory, on the initiator side of the OBI link.
// PARAMETERS
//  BLK_WORDS   4   32-bit words per block (block width = 32*BLK_WORDS = 128)
//  NBLK_WIDTH  16  width of the block-count field
// PORTS
//  clk_i          in   1        clock
//  rst_i          in   1        synchronous reset, active-high
//  cmd_valid_i    in   1        command request
//  cmd_ready_o    out  1        high only in IDLE
//  cmd_src_i      in   32       source byte address; bits[1:0] ignored (forced 0)
//  cmd_dst_i      in   32       destination byte address; bits[1:0] ignored (forced 0)
//  cmd_nblk_i     in   NBLK_WIDTH  number of blocks
//  blk_valid_o    out  1        block to core valid
//  blk_ready_i    in   1        core accepts block
//  blk_data_o     out  32*BLK_WORDS  word k (addr+4k) in bits[32k+31:32k]
//  res_valid_i    in   1        core result valid
//  res_ready_o    out  1        high only in RES_WAIT
//  res_data_i     in   32*BLK_WORDS  same packing as blk_data_o
//  busy_o         out  1        state != IDLE
//  done_o         out  1        one-cycle pulse at end of command (normal or abort)
//  err_o          out  1        sticky bus error; cleared on next accepted command
//  data_req_o     out  1        OBI request
//  data_gnt_i     in   1        OBI grant
//  data_addr_o    out  32       word-aligned address
//  data_we_o      out  1        1 = write
//  data_be_o      out  4        always 4'hF
//  data_wdata_o   out  32       write data
//  data_rvalid_i  in   1        OBI response valid
//  data_rdata_i   in   32       read data
//  data_err_i     in   1        response error, qualified by data_rvalid_i
// BEHAVIOUR
//  Reset: all outputs 0 except cmd_ready_o=1; all regs cleared; state IDLE.
//  FSM: IDLE -> RD_REQ -> RD_WAIT -> (RD_REQ | BLK_OUT) -> RES_WAIT -> WR_REQ -> WR_WAIT
//       -> (WR_REQ | RD_REQ | DONE) -> DONE -> IDLE.
//  IDLE: cmd_valid_i&cmd_ready_o latches src/dst/nblk, clears err_o. nblk==0 -> DONE directly, no bus traffic.
//  OBI rules: req asserted from the cycle after entering *_REQ. addr/we/be/wdata are stable while
//   req is high and req drops only on the cycle after gnt. One outstanding transaction max: no
//   new req until the rvalid for the previous one. rvalid is accepted at any latency >=1 after gnt.
//  rvalid is ignored in IDLE/BLK_OUT/RES_WAIT/DONE.
//  Throughput with gnt tied 1 and 1-cycle rvalid: 2 cycles/word.
//  RD_WAIT: on rvalid, rdata goes to word slot k; k++. k==BLK_WORDS -> BLK_OUT.
//  BLK_OUT: blk_valid_o=1, data stable until blk_ready_i; the handshake cycle goes to RES_WAIT.
//  RES_WAIT: res_ready_o=1; res_valid_i latches res_data_i -> WR_REQ, k=0.
//  WR_WAIT: rvalid -> k++. Last word -> blocks_left--. Then blocks_left!=0 -> RD_REQ, else DONE.
//  Addresses: src/dst pointers advance +4 per completed word, modulo 2^32 (wrap from
//   0xFFFFFFFC to 0).
//  Error: rvalid with data_err_i -> err_o=1, abort to DONE. No further reqs. A write whose data
//   came from an erroring read is never issued.
//  DONE: done_o=1 for exactly one cycle -> IDLE.
//  Reset mid-command: the transfer is abandoned the next edge; req drops. Stale rvalids that
//   arrive after reset are ignored.
//  cmd_valid_i while busy: ignored (cmd_ready_o=0).
// STRUCTURE
//  obi_pkg: typedef enum dma_state_e {IDLE,RD_REQ,RD_WAIT,BLK_OUT,RES_WAIT,WR_REQ,WR_WAIT,DONE};
//   localparam OBI_BE_FULL=4'hF; typedef struct obi_req_t {req,addr,we,be,wdata}.
//  Sub-module obi_single_master: one-transaction OBI engine (start/addr/we/wdata in;
//   req/gnt/rvalid handling; resp_valid/rdata/err out). The DMA FSM sequences it.
// TESTING (responder = team memory model, gnt=1, rvalid 1 cycle after req)
//  1. src=0x0, dst=0x100, nblk=1, mem[0..3]=1,2,3,4, core echoes XOR 0xFF -> blk_data_o=
//     {4,3,2,1}; mem[0x40..0x43]=0xFE,0xFD,0xFC,0xFB; done_o pulses once; err_o=0.
//  2. nblk=0 -> done_o pulses 2 cycles after cmd accept; data_req_o never asserted.
//  3. Random gnt stalls (0-3 cycles) and rvalid latency 1-5, nblk=3 -> req/addr stable until gnt;
//     never >1 outstanding; memory result identical to zero-stall run.
//  4. data_err_i on 2nd read word of block 1 (nblk=2) -> err_o=1, done_o pulse, zero writes issued.
//     Next cmd clears err_o.
//  5. src=0xFFFFFFF8, nblk=1 -> read addresses 0xFFFFFFF8, 0xFFFFFFFC, 0x0, 0x4.
//  6. rst_i pulsed during WR_WAIT -> data_req_o=0 the next cycle; busy_o=0; late rvalid ignored;
//     new cmd runs cleanly.

Source files
------------

// File: rtl/obi_block_dma_pkg.sv
// Shared types for the AES block DMA: FSM state encoding, the OBI request
// bundle driven by the single-transaction engine, and an address helper.
package obi_block_dma_pkg;

    localparam logic [3:0] OBI_BE_FULL = 4'hF;

    typedef enum logic [2:0] {
        IDLE,
        RD_REQ,
        RD_WAIT,
        BLK_OUT,
        RES_WAIT,
        WR_REQ,
        WR_WAIT,
        DONE
    } dma_state_e;

    typedef struct packed {
        logic        req;
        logic [31:0] addr;
        logic        we;
        logic [3:0]  be;
        logic [31:0] wdata;
    } obi_req_t;

    // Byte addresses from software may be unaligned; the bus only sees words.
    function automatic logic [31:0] word_align(input logic [31:0] a);
        return a & 32'hFFFF_FFFC;
    endfunction

endpackage

// File: rtl/obi_block_dma_single_master.sv
// obi_single_master: one-transaction OBI initiator engine.
//  start/addr/we/wdata : launch a transaction (only when no request is up and
//                        nothing is outstanding, or in the cycle its response lands)
//  granted             : request accepted by the bus this cycle
//  resp_valid/rdata/err: response for the outstanding transaction
//  obi/gnt/rvalid/...  : OBI initiator side
// The request bundle is fully registered, so addr/we/wdata cannot move while
// req is high; req drops on the edge after gnt.
module obi_single_master
    import obi_block_dma_pkg::*;
(
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        start,
    input  logic [31:0] addr,
    input  logic        we,
    input  logic [31:0] wdata,
    output logic        granted,
    output logic        resp_valid,
    output logic [31:0] resp_rdata,
    output logic        resp_err,
    output obi_req_t    obi,
    input  logic        gnt,
    input  logic        rvalid,
    input  logic [31:0] rdata,
    input  logic        err
);

    obi_req_t req_q;
    logic     pending_q;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            req_q     <= '0;
            pending_q <= 1'b0;
        end else begin
            if (req_q.req && gnt) begin
                req_q.req <= 1'b0;
                pending_q <= 1'b1;
            end
            if (pending_q && rvalid) begin
                pending_q <= 1'b0;
            end
            // Back-to-back: the sequencer may start the next word in the very
            // cycle the previous response arrives.
            if (start) begin
                req_q <= '{req: 1'b1, addr: addr, we: we, be: OBI_BE_FULL, wdata: wdata};
            end
        end
    end

    // rvalid outside an outstanding transaction (idle, or stale after reset)
    // never reaches the sequencer.
    assign granted    = req_q.req & gnt;
    assign resp_valid = pending_q & rvalid;
    assign resp_rdata = rdata;
    assign resp_err   = pending_q & rvalid & err;
    assign obi        = req_q;

endmodule

// File: rtl/obi_block_dma.sv
// obi_block_dma: reads N blocks of BLK_WORDS words from src, hands each block
// to the AES core, and writes the core's result block to dst over OBI.
//  cmd_*   : command handshake (src/dst byte addresses, block count)
//  blk_*   : block to the core (word k in bits [32k+31:32k])
//  res_*   : result block from the core, same packing
//  busy_o/done_o/err_o : status; err_o is sticky until the next command
//  data_*  : OBI initiator port, one outstanding transaction at most
module obi_block_dma
    import obi_block_dma_pkg::*;
#(
    parameter int BLK_WORDS  = 4,
    parameter int NBLK_WIDTH = 16
) (
    input  logic                    clk_i,
    input  logic                    rst_i,
    input  logic                    cmd_valid_i,
    output logic                    cmd_ready_o,
    input  logic [31:0]             cmd_src_i,
    input  logic [31:0]             cmd_dst_i,
    input  logic [NBLK_WIDTH-1:0]   cmd_nblk_i,
    output logic                    blk_valid_o,
    input  logic                    blk_ready_i,
    output logic [32*BLK_WORDS-1:0] blk_data_o,
    input  logic                    res_valid_i,
    output logic                    res_ready_o,
    input  logic [32*BLK_WORDS-1:0] res_data_i,
    output logic                    busy_o,
    output logic                    done_o,
    output logic                    err_o,
    output logic                    data_req_o,
    input  logic                    data_gnt_i,
    output logic [31:0]             data_addr_o,
    output logic                    data_we_o,
    output logic [3:0]              data_be_o,
    output logic [31:0]             data_wdata_o,
    input  logic                    data_rvalid_i,
    input  logic [31:0]             data_rdata_i,
    input  logic                    data_err_i
);

    localparam int KW = (BLK_WORDS > 1) ? $clog2(BLK_WORDS) : 1;

    dma_state_e                   state;
    logic [31:0]                  src_q, dst_q;
    logic [NBLK_WIDTH-1:0]        left_q;
    logic [KW-1:0]                k_q;
    logic [BLK_WORDS-1:0][31:0]   blk_q, res_q;
    logic                         err_q, done_q;

    logic        m_start, m_we, m_granted, m_resp_valid, m_resp_err;
    logic [31:0] m_addr, m_wdata, m_rdata;
    obi_req_t    obi;

    logic [KW-1:0] k_nxt;
    logic          last_word;

    assign k_nxt     = k_q + 1'b1;
    assign last_word = (k_q == KW'(BLK_WORDS - 1));

    // Next transaction is launched on the same edge the FSM enters *_REQ,
    // so req is up for the whole REQ state and a word costs 2 cycles at best.
    always_comb begin
        m_start = 1'b0;
        m_addr  = src_q;
        m_we    = 1'b0;
        m_wdata = '0;
        case (state)
            IDLE: if (cmd_valid_i && cmd_nblk_i != '0) begin
                m_start = 1'b1;
                m_addr  = word_align(cmd_src_i);
            end
            RD_WAIT: if (m_resp_valid && !m_resp_err && !last_word) begin
                m_start = 1'b1;
                m_addr  = src_q + 32'd4;
            end
            RES_WAIT: if (res_valid_i) begin
                m_start = 1'b1;
                m_addr  = dst_q;
                m_we    = 1'b1;
                m_wdata = res_data_i[31:0];
            end
            WR_WAIT: if (m_resp_valid && !m_resp_err) begin
                if (!last_word) begin
                    m_start = 1'b1;
                    m_addr  = dst_q + 32'd4;
                    m_we    = 1'b1;
                    m_wdata = res_q[k_nxt];
                end else if (left_q != NBLK_WIDTH'(1)) begin
                    // src_q already points at the next block
                    m_start = 1'b1;
                    m_addr  = src_q;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state  <= IDLE;
            src_q  <= '0;
            dst_q  <= '0;
            left_q <= '0;
            k_q    <= '0;
            blk_q  <= '0;
            res_q  <= '0;
            err_q  <= 1'b0;
            done_q <= 1'b0;
        end else begin
            // done lands the cycle after DONE, i.e. back in IDLE
            done_q <= (state == DONE);
            case (state)
                IDLE: if (cmd_valid_i) begin
                    src_q  <= word_align(cmd_src_i);
                    dst_q  <= word_align(cmd_dst_i);
                    left_q <= cmd_nblk_i;
                    k_q    <= '0;
                    err_q  <= 1'b0;
                    state  <= (cmd_nblk_i == '0) ? DONE : RD_REQ;
                end
                RD_REQ: if (m_granted) state <= RD_WAIT;
                RD_WAIT: if (m_resp_valid) begin
                    if (m_resp_err) begin
                        err_q <= 1'b1;
                        state <= DONE;
                    end else begin
                        blk_q[k_q] <= m_rdata;
                        src_q      <= src_q + 32'd4;
                        k_q        <= last_word ? '0 : k_nxt;
                        state      <= last_word ? BLK_OUT : RD_REQ;
                    end
                end
                BLK_OUT: if (blk_ready_i) state <= RES_WAIT;
                RES_WAIT: if (res_valid_i) begin
                    res_q <= res_data_i;
                    k_q   <= '0;
                    state <= WR_REQ;
                end
                WR_REQ: if (m_granted) state <= WR_WAIT;
                WR_WAIT: if (m_resp_valid) begin
                    if (m_resp_err) begin
                        err_q <= 1'b1;
                        state <= DONE;
                    end else begin
                        dst_q <= dst_q + 32'd4;
                        if (!last_word) begin
                            k_q   <= k_nxt;
                            state <= WR_REQ;
                        end else begin
                            k_q    <= '0;
                            left_q <= left_q - 1'b1;
                            state  <= (left_q != NBLK_WIDTH'(1)) ? RD_REQ : DONE;
                        end
                    end
                end
                DONE:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    obi_single_master u_master (
        .clk_i      (clk_i),
        .rst_i      (rst_i),
        .start      (m_start),
        .addr       (m_addr),
        .we         (m_we),
        .wdata      (m_wdata),
        .granted    (m_granted),
        .resp_valid (m_resp_valid),
        .resp_rdata (m_rdata),
        .resp_err   (m_resp_err),
        .obi        (obi),
        .gnt        (data_gnt_i),
        .rvalid     (data_rvalid_i),
        .rdata      (data_rdata_i),
        .err        (data_err_i)
    );

    assign cmd_ready_o  = (state == IDLE);
    assign busy_o       = (state != IDLE);
    assign blk_valid_o  = (state == BLK_OUT);
    assign res_ready_o  = (state == RES_WAIT);
    assign blk_data_o   = blk_q;
    assign done_o       = done_q;
    assign err_o        = err_q;
    assign data_req_o   = obi.req;
    assign data_addr_o  = obi.addr;
    assign data_we_o    = obi.we;
    assign data_be_o    = obi.be;
    assign data_wdata_o = obi.wdata;

endmodule

// File: tb/tb_obi_block_dma.sv
module tb_obi_block_dma;

    localparam int W = 4;

    logic         clk = 1'b0;
    logic         rst;
    logic         cmd_valid, cmd_ready;
    logic [31:0]  cmd_src, cmd_dst;
    logic [15:0]  cmd_nblk;
    logic         blk_valid, blk_ready;
    logic [127:0] blk_data;
    logic         res_valid, res_ready;
    logic [127:0] res_data;
    logic         busy, done, err;
    logic         data_req, data_gnt, data_we, data_rvalid, data_err;
    logic [31:0]  data_addr, data_wdata, data_rdata;
    logic [3:0]   data_be;

    always #5 clk = ~clk;

    obi_block_dma #(.BLK_WORDS(W), .NBLK_WIDTH(16)) dut (
        .clk_i(clk), .rst_i(rst),
        .cmd_valid_i(cmd_valid), .cmd_ready_o(cmd_ready),
        .cmd_src_i(cmd_src), .cmd_dst_i(cmd_dst), .cmd_nblk_i(cmd_nblk),
        .blk_valid_o(blk_valid), .blk_ready_i(blk_ready), .blk_data_o(blk_data),
        .res_valid_i(res_valid), .res_ready_o(res_ready), .res_data_i(res_data),
        .busy_o(busy), .done_o(done), .err_o(err),
        .data_req_o(data_req), .data_gnt_i(data_gnt), .data_addr_o(data_addr),
        .data_we_o(data_we), .data_be_o(data_be), .data_wdata_o(data_wdata),
        .data_rvalid_i(data_rvalid), .data_rdata_i(data_rdata), .data_err_i(data_err)
    );

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] want);
        n_cmp++;
        if (act !== want) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h", nm, act, want);
        end
    endtask

    // ---------------- memory + behavioural model ----------------
    logic [31:0] mem [bit [29:0]];

    function automatic logic [31:0] rd(input bit [29:0] a);
        if (mem.exists(a)) return mem[a];
        return {2'b10, a};
    endfunction

    typedef struct { logic [31:0] addr; logic we; logic [31:0] data; } tx_t;
    tx_t          exp_tx[$];
    logic [127:0] exp_blk[$];

    // Expected bus transactions and core blocks for one command. err_idx is
    // the zero-based read that returns an error (-1: none).
    task automatic model_cmd(input logic [31:0] src, input logic [31:0] dst,
                             input int nblk, input int err_idx);
        logic [31:0]  s, d, a, v;
        logic [127:0] blk;
        int           idx;
        s = src & 32'hFFFF_FFFC;
        d = dst & 32'hFFFF_FFFC;
        idx = 0;
        for (int b = 0; b < nblk; b++) begin
            for (int k = 0; k < W; k++) begin
                a = s + 32'(4 * (b * W + k));
                v = rd(a[31:2]);
                exp_tx.push_back('{a, 1'b0, v});
                blk[32*k +: 32] = v;
                if (idx == err_idx) return;
                idx++;
            end
            exp_blk.push_back(blk);
            for (int k = 0; k < W; k++)
                exp_tx.push_back('{d + 32'(4 * (b * W + k)), 1'b1, blk[32*k +: 32] ^ 32'hFF});
        end
    endtask

    // ---------------- responder, core and per-cycle checker ----------------
    bit           stall_en = 0, err_en = 0;
    int           lat_fix = 0;
    logic [31:0]  err_addr = '0;
    bit           p_req, p_gnt, p_we, p_rvalid, p_rst, p_blkv, p_blkr, p_resv, p_resr;
    logic [31:0]  p_addr, p_wdata, r_data;
    logic [127:0] p_blk, last_blk, core_res;
    bit           pend = 0, r_err, core_busy = 0, req_seen = 0;
    int           cnt, stall_left = 0, core_cnt, n_wr = 0, n_rd = 0, done_cnt = 0;
    logic [31:0]  rd_addrs[$];
    tx_t          e;

    initial begin
        data_gnt = 0; data_rvalid = 0; data_rdata = 0; data_err = 0;
        blk_ready = 0; res_valid = 0; res_data = '0;
        forever begin
            @(negedge clk);
            if (p_rvalid) pend = 0;
            if (p_req && p_gnt) begin
                chk("single_outstanding", pend, 0);
                chk("tx_expected", exp_tx.size() != 0, 1);
                if (exp_tx.size() != 0) begin
                    e = exp_tx.pop_front();
                    chk("tx_addr", p_addr, e.addr);
                    chk("tx_we", p_we, e.we);
                    if (e.we) chk("tx_wdata", p_wdata, e.data);
                end
                if (p_we) begin
                    mem[p_addr[31:2]] = p_wdata;
                    n_wr++;
                end else begin
                    r_data = rd(p_addr[31:2]);
                    n_rd++;
                    rd_addrs.push_back(p_addr);
                end
                r_err = err_en && !p_we && (p_addr == err_addr);
                pend  = 1;
                cnt   = (lat_fix != 0) ? lat_fix : (stall_en ? int'($urandom_range(1, 5)) : 1);
            end
            if (p_req && !p_gnt && !p_rst) begin
                chk("req_held", data_req, 1);
                chk("addr_held", data_addr, p_addr);
                chk("we_held", data_we, p_we);
                chk("wdata_held", data_wdata, p_wdata);
            end
            if (pend) chk("no_req_while_outstanding", data_req, 0);
            if (data_req === 1'b1) begin
                req_seen = 1;
                chk("be_full", data_be, 4'hF);
            end
            chk("ready_only_idle", cmd_ready, !busy);

            data_rvalid = 0; data_err = 0; data_rdata = $urandom;
            if (pend && cnt > 0) begin
                cnt--;
                if (cnt == 0) begin
                    data_rvalid = 1; data_rdata = r_data; data_err = r_err;
                end
            end
            if (!stall_en) data_gnt = 1;
            else if (data_req === 1'b1) begin
                if (!p_req || p_gnt) stall_left = $urandom_range(0, 3);
                data_gnt = (stall_left == 0);
                if (stall_left != 0) stall_left--;
            end else data_gnt = 0;

            if (p_blkv && p_blkr) begin
                if (exp_blk.size() != 0) void'(exp_blk.pop_front());
                last_blk  = p_blk;
                core_res  = p_blk ^ {4{32'h0000_00FF}};
                core_busy = 1;
                core_cnt  = stall_en ? int'($urandom_range(0, 3)) : 0;
            end
            if (p_resv && p_resr) begin
                core_busy = 0; res_valid = 0;
            end
            if (blk_valid === 1'b1) begin
                chk("blk_expected", exp_blk.size() != 0, 1);
                if (exp_blk.size() != 0) chk("blk_data", blk_data, exp_blk[0]);
                blk_ready = stall_en ? 1'($urandom_range(0, 1)) : 1'b1;
            end else blk_ready = 0;
            if (core_busy && !res_valid) begin
                if (core_cnt == 0) begin
                    res_valid = 1; res_data = core_res;
                end else core_cnt--;
            end
            if (done === 1'b1) done_cnt++;
            if (rst) begin
                exp_tx.delete(); exp_blk.delete();
                core_busy = 0; res_valid = 0; blk_ready = 0;
            end
            p_req = data_req; p_gnt = data_gnt; p_addr = data_addr; p_we = data_we;
            p_wdata = data_wdata; p_rvalid = data_rvalid; p_rst = rst;
            p_blkv = blk_valid; p_blkr = blk_ready; p_blk = blk_data;
            p_resv = res_valid; p_resr = res_ready;
        end
    end

    // ---------------- directed tests ----------------
    task automatic issue(input logic [31:0] s, input logic [31:0] d, input int n);
        @(posedge clk); #1;
        cmd_valid = 1; cmd_src = s; cmd_dst = d; cmd_nblk = 16'(n);
        @(posedge clk); #1;
        cmd_valid = 0;
    endtask

    task automatic run_cmd(input logic [31:0] s, input logic [31:0] d, input int n, input int ei);
        bit got;
        model_cmd(s, d, n, ei);
        issue(s, d, n);
        got = 0;
        for (int k = 0; k < 4000; k++) begin
            @(negedge clk);
            if (done === 1'b1) begin got = 1; break; end
        end
        chk("done_seen", got, 1);
        chk("tx_all_done", exp_tx.size(), 0);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    logic [31:0] snap[12];
    logic [31:0] exp5[4];
    int          d0, w0;
    bit          got;

    initial begin
        rst = 1; cmd_valid = 0; cmd_src = '0; cmd_dst = '0; cmd_nblk = '0;
        repeat (3) @(posedge clk);
        #1 rst = 0;
        @(negedge clk);
        chk("rst_cmd_ready", cmd_ready, 1);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_err", err, 0);
        chk("rst_req", data_req, 0);
        chk("rst_blk_valid", blk_valid, 0);
        chk("rst_res_ready", res_ready, 0);

        // 1: single block, core XORs 0xFF
        for (int i = 0; i < 4; i++) mem[30'(i)] = 32'(i + 1);
        d0 = done_cnt;
        run_cmd(32'h0, 32'h100, 1, -1);
        chk("t1_blk", last_blk, 128'h00000004_00000003_00000002_00000001);
        chk("t1_m40", mem[30'h40], 32'hFE);
        chk("t1_m41", mem[30'h41], 32'hFD);
        chk("t1_m42", mem[30'h42], 32'hFC);
        chk("t1_m43", mem[30'h43], 32'hFB);
        @(negedge clk);
        chk("t1_done_once", done_cnt - d0, 1);
        chk("t1_err", err, 0);

        // 2: nblk=0 -> done two cycles after accept, no bus traffic
        req_seen = 0;
        issue(32'h40, 32'h80, 0);
        @(negedge clk); chk("t2_done_c1", done, 0);
        @(negedge clk); chk("t2_done_c2", done, 1);
        @(negedge clk); chk("t2_done_c3", done, 0);
        chk("t2_no_req", req_seen, 0);

        // 3: three blocks, zero-stall reference then random stalls
        for (int i = 0; i < 12; i++) mem[30'hC0 + 30'(i)] = 32'h1111 * (i + 1) + 7;
        run_cmd(32'h300, 32'h200, 3, -1);
        for (int i = 0; i < 12; i++) begin
            snap[i] = mem[30'h80 + 30'(i)];
            mem[30'h80 + 30'(i)] = '0;
        end
        stall_en = 1;
        run_cmd(32'h300, 32'h200, 3, -1);
        stall_en = 0;
        repeat (8) @(negedge clk);
        for (int i = 0; i < 12; i++) chk("t3_same_result", mem[30'h80 + 30'(i)], snap[i]);
        chk("t3_word0", snap[0], 32'h1118 ^ 32'hFF);

        // 4: error on 2nd read word of the first block
        err_en = 1; err_addr = 32'h404;
        w0 = n_wr; d0 = done_cnt;
        run_cmd(32'h400, 32'h500, 2, 1);
        @(negedge clk);
        err_en = 0;
        chk("t4_err", err, 1);
        chk("t4_no_writes", n_wr - w0, 0);
        chk("t4_done_once", done_cnt - d0, 1);
        run_cmd(32'h0, 32'h0, 0, -1);
        chk("t4_err_cleared", err, 0);

        // 5: source address wrap
        rd_addrs.delete();
        exp5[0] = 32'hFFFF_FFF8; exp5[1] = 32'hFFFF_FFFC; exp5[2] = 32'h0; exp5[3] = 32'h4;
        run_cmd(32'hFFFF_FFF8, 32'h600, 1, -1);
        chk("t5_nreads", rd_addrs.size(), 4);
        for (int i = 0; i < 4 && i < rd_addrs.size(); i++) chk("t5_rd_addr", rd_addrs[i], exp5[i]);

        // 6: reset while a write is outstanding
        for (int i = 0; i < 4; i++) mem[30'h1C0 + 30'(i)] = 32'(16 * (i + 1));
        lat_fix = 5; w0 = n_wr; d0 = done_cnt;
        model_cmd(32'h700, 32'h800, 1, -1);
        issue(32'h700, 32'h800, 1);
        got = 0;
        for (int k = 0; k < 500; k++) begin
            @(negedge clk);
            if (n_wr != w0) begin got = 1; break; end
        end
        chk("t6_reached_wr_wait", got, 1);
        @(posedge clk); #1 rst = 1;
        @(posedge clk); #1 rst = 0;
        @(negedge clk);
        chk("t6_req_dropped", data_req, 0);
        chk("t6_busy", busy, 0);
        got = 0;
        for (int k = 0; k < 50; k++) begin
            if (!pend) begin got = 1; break; end
            @(negedge clk);
        end
        chk("t6_stale_rvalid_drained", got, 1);
        @(negedge clk);
        chk("t6_idle_after_stale", busy, 0);
        chk("t6_no_done", done_cnt - d0, 0);
        chk("t6_no_err", err, 0);
        lat_fix = 0;
        run_cmd(32'h700, 32'h900, 1, -1);
        @(negedge clk);
        chk("t6_err_clean", err, 0);
        chk("t6_m0", mem[30'h240], 32'hEF);
        chk("t6_m1", mem[30'h241], 32'hDF);
        chk("t6_m2", mem[30'h242], 32'hCF);
        chk("t6_m3", mem[30'h243], 32'hBF);

        repeat (4) @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
